// File: rtl/fetch.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, runs the instruction-memory
// req/ack handshake and drives the IF/ID register, with a one-word skid for ID stalls.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_con_stall,
  input  logic        i_con_ifbranch,
  input  logic [31:0] i_addr_pcadd,
  input  logic        i_con_jump,
  input  logic [31:0] i_addr_jump,
  output logic        o_con_imemreq,
  output logic [31:0] o_addr_imem,
  input  logic        i_con_imemack,
  input  logic [31:0] i_data_imem,
  output logic [31:0] o_addr_pc4,
  output logic [31:0] o_data_instr,
  output logic        o_con_valid
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_KILL} state_e;

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        req;
  logic        ack;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    valid_d      = valid_q;

    // run_q holds off the first request until one edge after reset release
    req      = run_q & (state_q != S_HOLD);
    ack      = i_con_imemack & req;
    redir    = ~i_con_stall & (i_con_jump | i_con_ifbranch);
    target   = (i_con_jump ? i_addr_jump : i_addr_pcadd) & 32'hFFFF_FFFC;
    pc_plus4 = pc_q + 32'd4;

    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          if (redir) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (ack) begin
              pc_d = target;
            end else begin
              pend_d  = target;
              state_d = S_KILL;
            end
          end else if (ack && !i_con_stall) begin
            pc4_d   = pc_plus4;
            instr_d = i_data_imem;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else if (ack) begin
            skid_pc4_d   = pc_plus4;
            skid_instr_d = i_data_imem;
            pc_d         = pc_plus4;
            state_d      = S_HOLD;
          end else if (!i_con_stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc_d    = target;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = S_FETCH;
          end else if (!i_con_stall) begin
            pc4_d   = skid_pc4_q;
            instr_d = skid_instr_q;
            valid_d = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_KILL: begin
          // the in-flight word belongs to the wrong path; wait it out and drop it
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (ack) begin
            pc_d    = pend_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= S_FETCH;
      run_q        <= 1'b0;
      pc_q         <= RESET_PC;
      pend_q       <= RESET_PC;
      skid_pc4_q   <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      pc4_q        <= 32'h0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

  assign o_con_imemreq = req;
  assign o_addr_imem   = pc_q;
  assign o_addr_pc4    = pc4_q;
  assign o_data_instr  = instr_q;
  assign o_con_valid   = valid_q;

endmodule
